stbq_handshake_tx: RTL and testbench

//  Source-side half of a four-phase req/ack strobe crossing. Counts strobes in
//  the local domain, so none are lost while a transfer is in flight, and sends

---
 rtl/stbq_handshake_tx_pkg.sv | 10 +
 rtl/stbq_handshake_tx_if.sv | 22 ++
 rtl/stbq_handshake_tx_ff_sync.sv | 18 +
 rtl/stbq_handshake_tx.sv | 77 +++++++
 tb/tb_stbq_handshake_tx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/stbq_handshake_tx_pkg.sv
// Shared types for the strobe-crossing transmitter: FSM state encoding.
package stbq_handshake_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/stbq_handshake_tx_if.sv
// Handshake/bus bundle between the strobe-crossing transmitter and its environment.
interface stbq_handshake_tx_if #(
    parameter int LGCOUNT = 4
);
    logic               i_stb;
    logic               i_clr_overflow;
    logic               i_ack;
    logic               o_req;
    logic               o_done;
    logic [LGCOUNT-1:0] o_pending;
    logic               o_overflow;

    // master: the transmitter itself; slave: whoever feeds strobes and returns ack
    modport master (
        input  i_stb, i_clr_overflow, i_ack,
        output o_req, o_done, o_pending, o_overflow
    );
    modport slave (
        output i_stb, i_clr_overflow, i_ack,
        input  o_req, o_done, o_pending, o_overflow
    );
endinterface

// File: rtl/stbq_handshake_tx_ff_sync.sv
// Multi-flop level synchronizer, cleared by async reset; reusable on either side.
module ff_sync #(
    parameter int NFF = 2
) (
    input  logic i_clk,
    input  logic i_areset_n,
    input  logic i_d,
    output logic o_q
);
    logic [NFF-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) sync_q <= '0;
        else             sync_q <= {sync_q[NFF-2:0], i_d};
    end

    assign o_q = sync_q[NFF-1];
endmodule

// File: rtl/stbq_handshake_tx.sv
// Source side of a four-phase req/ack strobe crossing: counts strobes locally and
// delivers them one per req/ack round trip.
module stbq_handshake_tx
    import stbq_handshake_tx_pkg::*;
#(
    parameter int NFF     = 2,
    parameter int LGCOUNT = 4
) (
    input logic                  i_clk,
    input logic                  i_areset_n,
    stbq_handshake_tx_if.master  bus
);
    localparam logic [LGCOUNT-1:0] CNT_MAX = '1;

    tx_state_e          state_q, state_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [LGCOUNT-1:0] pend_q, pend_d;
    logic               ack_s;
    logic               dec, accept, drop;

    ff_sync #(.NFF(NFF)) u_ack_sync (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_d        (bus.i_ack),
        .o_q        (ack_s)
    );

    // IDLE also holds off while ack_s is high, so req never rises into a stale ack
    always_comb begin
        state_d = state_q;
        dec     = 1'b0;
        case (state_q)
            ST_IDLE:    if (pend_q != '0 && !ack_s) state_d = ST_REQ;
            ST_REQ:     if (ack_s) begin
                            state_d = ST_RELEASE;
                            dec     = 1'b1;
                        end
            ST_RELEASE: if (!ack_s) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        req_d  = (state_d == ST_REQ);
        done_d = dec;
    end

    // At full count a strobe still fits if an event leaves in the same cycle
    always_comb begin
        accept = bus.i_stb && ((pend_q != CNT_MAX) || dec);
        drop   = bus.i_stb && !accept;
        pend_d = pend_q + LGCOUNT'(accept) - LGCOUNT'(dec);
        ovf_d  = ovf_q;
        if (drop)                    ovf_d = 1'b1;
        else if (bus.i_clr_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.o_req      = req_q;
    assign bus.o_done     = done_q;
    assign bus.o_pending  = pend_q;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_stbq_handshake_tx.sv
// Bench: two transmitters (LGCOUNT 4 and 2), each with its own dest ack model,
// checked every cycle against a protocol-level reference model.
module tb_stbq_handshake_tx;
    localparam int NFF = 2;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_REL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stbq_handshake_tx_if #(.LGCOUNT(4)) if4 ();
    stbq_handshake_tx_if #(.LGCOUNT(2)) if2 ();

    stbq_handshake_tx #(.NFF(NFF), .LGCOUNT(4)) dut4 (.i_clk(clk), .i_areset_n(rst_n), .bus(if4.master));
    stbq_handshake_tx #(.NFF(NFF), .LGCOUNT(2)) dut2 (.i_clk(clk), .i_areset_n(rst_n), .bus(if2.master));

    logic       stb_v [2];
    logic       clr_v [2];
    logic       ack_v [2];
    logic       req_w [2];
    logic       done_w[2];
    logic       ovf_w [2];
    logic [3:0] pend_w[2];

    assign if4.i_stb = stb_v[0];  assign if4.i_clr_overflow = clr_v[0];  assign if4.i_ack = ack_v[0];
    assign if2.i_stb = stb_v[1];  assign if2.i_clr_overflow = clr_v[1];  assign if2.i_ack = ack_v[1];
    assign req_w[0] = if4.o_req;  assign done_w[0] = if4.o_done;  assign ovf_w[0] = if4.o_overflow;
    assign req_w[1] = if2.o_req;  assign done_w[1] = if2.o_done;  assign ovf_w[1] = if2.o_overflow;
    assign pend_w[0] = if4.o_pending;
    assign pend_w[1] = {2'b00, if2.o_pending};

    // reference model state
    int mp[2], mph[2], mreq[2], mdone[2], movf[2], macc[2], acks_used[2];
    int ash[2][NFF];
    int mmax[2];
    // dest model and bookkeeping
    int mode[2], dly[2], rndd[2], dcnt[2], prev_req[2], dn[2];
    int pk;
    int n_cmp, n_err;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mp[k] = 0; mph[k] = PH_IDLE; mreq[k] = 0; mdone[k] = 0; movf[k] = 0;
            for (int j = 0; j < NFF; j++) ash[k][j] = 0;
            dcnt[k] = 0; prev_req[k] = 0;
        end
    endtask

    // One clock of the protocol rules, using the ack value seen NFF edges late
    task automatic model_step(input int k, input int s, input int c);
        int a, dec, acc, nph;
        a   = ash[k][NFF-1];
        acks_used[k] = a;
        dec = (mph[k] == PH_REQ && a == 1) ? 1 : 0;
        acc = (s == 1 && (mp[k] < mmax[k] || dec == 1)) ? 1 : 0;
        nph = mph[k];
        if (mph[k] == PH_IDLE && mp[k] > 0 && a == 0) nph = PH_REQ;
        else if (mph[k] == PH_REQ && a == 1)          nph = PH_REL;
        else if (mph[k] == PH_REL && a == 0)          nph = PH_IDLE;
        mp[k]    = mp[k] + acc - dec;
        macc[k] += acc;
        mreq[k]  = (nph == PH_REQ) ? 1 : 0;
        mdone[k] = dec;
        if (s == 1 && acc == 0) movf[k] = 1;
        else if (c == 1)        movf[k] = 0;
        mph[k] = nph;
        for (int j = NFF-1; j > 0; j--) ash[k][j] = ash[k][j-1];
        ash[k][0] = ack_v[k];
    endtask

    function automatic bit model_idle(input int k);
        bit r;
        r = (mph[k] == PH_IDLE && mp[k] == 0 && ack_v[k] == 1'b0);
        for (int j = 0; j < NFF; j++) if (ash[k][j] != 0) r = 0;
        return r;
    endfunction

    task automatic cyc(input logic s0, input logic s1, input logic c0 = 1'b0, input logic c1 = 1'b0);
        stb_v[0] = s0; stb_v[1] = s1; clr_v[0] = c0; clr_v[1] = c1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, int'(stb_v[k]), int'(clr_v[k]));
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req[%0d]", k),  int'(req_w[k]),  mreq[k]);
            chk($sformatf("done[%0d]", k), int'(done_w[k]), mdone[k]);
            chk($sformatf("pend[%0d]", k), int'(pend_w[k]), mp[k]);
            chk($sformatf("ovf[%0d]", k),  int'(ovf_w[k]),  movf[k]);
            if (req_w[k] === 1'b1 && prev_req[k] == 0)
                chk($sformatf("req_rise_ack_s[%0d]", k), acks_used[k], 0);
            prev_req[k] = int'(req_w[k]);
            dn[k] += int'(done_w[k]);
        end
        if (int'(pend_w[0]) > pk) pk = int'(pend_w[0]);
        stb_v[0] = 1'b0; stb_v[1] = 1'b0; clr_v[0] = 1'b0; clr_v[1] = 1'b0;
        // dest model: follow o_req after dly cycles
        for (int k = 0; k < 2; k++) begin
            if (mode[k] == 0) begin
                if (ack_v[k] !== req_w[k]) begin
                    if (dcnt[k] >= dly[k]) begin
                        ack_v[k] = req_w[k];
                        dcnt[k]  = 0;
                        if (rndd[k] != 0) dly[k] = $urandom_range(0, 20);
                    end else dcnt[k]++;
                end else dcnt[k] = 0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(model_idle(0) && model_idle(1)) && n < 1000) begin
            cyc(1'b0, 1'b0);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_req[%0d]", k),  int'(req_w[k]),  0);
            chk($sformatf("rst_done[%0d]", k), int'(done_w[k]), 0);
            chk($sformatf("rst_pend[%0d]", k), int'(pend_w[k]), 0);
            chk($sformatf("rst_ovf[%0d]", k),  int'(ovf_w[k]),  0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, d0, a0, n;
        int ba[2], bd[2];
        n_cmp = 0; n_err = 0; pk = 0;
        mmax[0] = 15; mmax[1] = 3;
        for (int k = 0; k < 2; k++) begin
            stb_v[k] = 1'b0; clr_v[k] = 1'b0; ack_v[k] = 1'b0;
            mode[k] = 0; dly[k] = 3; rndd[k] = 0; dn[k] = 0; macc[k] = 0;
        end
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // single strobe, dest acks 3 clk after o_req
        d0 = dn[0];
        cyc(1'b1, 1'b0);
        lat = 1;
        while (req_w[0] !== 1'b1 && lat < 20) begin
            cyc(1'b0, 1'b0);
            lat++;
        end
        chk("single_req_lat", lat, 2);
        drain();
        chk("single_done_cnt", dn[0] - d0, 1);
        chk("single_pend_end", int'(pend_w[0]), 0);

        // five back-to-back strobes
        d0 = dn[0]; pk = 0;
        repeat (5) cyc(1'b1, 1'b0);
        drain();
        chk("b2b_peak", pk, 5);
        chk("b2b_done_cnt", dn[0] - d0, 5);

        // saturation on the LGCOUNT=2 instance with ack held off
        mode[1] = 1; ack_v[1] = 1'b0;
        repeat (4) cyc(1'b0, 1'b1);
        chk("sat_pend", int'(pend_w[1]), 3);
        chk("sat_ovf_set", int'(ovf_w[1]), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_ovf_clr", int'(ovf_w[1]), 0);
        mode[1] = 0; dly[1] = 0; ack_v[1] = 1'b1;
        n = 0;
        while (!(mph[1] == PH_REQ && ash[1][NFF-1] == 1) && n < 50) begin
            cyc(1'b0, 1'b0);
            n++;
        end
        if (n >= 50) chk("sat_wait_timeout", 1, 0);
        cyc(1'b0, 1'b1);
        chk("sat_same_cycle_pend", int'(pend_w[1]), 3);
        chk("sat_same_cycle_ovf", int'(ovf_w[1]), 0);
        drain();

        // reset while in REQ with ack high and two events pending
        mode[0] = 1; ack_v[0] = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("pre_rst_req", int'(req_w[0]), 1);
        chk("pre_rst_pend", int'(pend_w[0]), 2);
        ack_v[0] = 1'b1;
        do_reset();
        repeat (4) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            chk("rst_ack_hold_req", int'(req_w[0]), 0);
        end
        ack_v[0] = 1'b0; mode[0] = 0; dly[0] = 2;
        drain();
        chk("rst_pend_end", int'(pend_w[0]), 0);

        // randomized traffic and ack delays
        for (int k = 0; k < 2; k++) begin
            ba[k] = macc[k]; bd[k] = dn[k];
            mode[k] = 0; rndd[k] = 1; dly[k] = $urandom_range(0, 20);
        end
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
        drain();
        for (int k = 0; k < 2; k++) begin
            a0 = macc[k] - ba[k];
            chk($sformatf("rand_done_vs_acc[%0d]", k), dn[k] - bd[k], a0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
